// File: rtl/fpmul_stream_pkg.sv
// Shared types for the FP multiplier stream master: word width, FSM states,
// and the operand / result records carried through the two FIFOs.
package fpmul_stream_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        AWAIT
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
    } op_pair_t;

    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic [WORD_W-1:0] z;
    } result_t;

endpackage

// File: rtl/fpmul_stream_master_if.sv
// Handshake bundle between the stream master and the FP multiplier wrapper.
// master: drives operands and result-ready; slave: the multiplier side.
interface fpmul_stream_master_if;
    import fpmul_stream_pkg::*;

    logic [WORD_W-1:0] op_a;
    logic [WORD_W-1:0] op_b;
    logic              op_valid;
    logic              op_ready;
    logic [WORD_W-1:0] res_data;
    logic              res_valid;
    logic              res_ready;

    modport master (
        output op_a, op_b, op_valid, res_ready,
        input  op_ready, res_data, res_valid
    );

    modport slave (
        input  op_a, op_b, op_valid, res_ready,
        output op_ready, res_data, res_valid
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter. A push while full is accepted
// only when a pop happens in the same cycle (occupancy then stays full).
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             wr_en;
    logic             rd_en;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    // Storage array; contents need no reset since cnt gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fpmul_stream_master.sv
// Operand source / result sink for the FP multiplier wrapper. Host operand
// pairs are queued, issued one at a time, and the {A,B,Z} triple of each
// completed product is queued for the host. Includes result backpressure
// injection and a response watchdog.
module fpmul_stream_master
    import fpmul_stream_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WORD_W-1:0]    cmd_a,
    input  logic [WORD_W-1:0]    cmd_b,
    fpmul_stream_master_if.master mul,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_W-1:0]    rsp_a,
    output logic [WORD_W-1:0]    rsp_b,
    output logic [WORD_W-1:0]    rsp_z,
    input  logic                 stall_en,
    output logic [CNT_W-1:0]     issued_cnt,
    output logic [CNT_W-1:0]     completed_cnt,
    output logic                 timeout_err,
    output logic                 busy
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    op_pair_t         pair_q, pair_d;
    logic             op_valid_q, op_valid_d;
    logic             res_ready_q, res_ready_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] completed_q, completed_d;
    logic             timeout_q, timeout_d;

    op_pair_t op_din, op_head;
    result_t  res_din, res_head;
    logic     op_full, op_empty, op_push, op_pop;
    logic     res_full, res_empty, capture, rsp_pop;

    assign op_din    = '{a: cmd_a, b: cmd_b};
    assign cmd_ready = !op_full;
    assign op_push   = cmd_valid && cmd_ready;

    sync_fifo #(.WIDTH($bits(op_pair_t)), .DEPTH(DEPTH)) u_op_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (op_push),
        .din   (op_din),
        .full  (op_full),
        .pop   (op_pop),
        .dout  (op_head),
        .empty (op_empty)
    );

    // Operands stay registered through AWAIT: the multiplier samples them
    // directly along its pipeline, so they double as the A/B of the result.
    assign res_din = '{a: pair_q.a, b: pair_q.b, z: mul.res_data};
    assign rsp_pop = rsp_valid && rsp_ready;

    sync_fifo #(.WIDTH($bits(result_t)), .DEPTH(DEPTH)) u_res_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (capture),
        .din   (res_din),
        .full  (res_full),
        .pop   (rsp_pop),
        .dout  (res_head),
        .empty (res_empty)
    );

    // Next-state and registered-output logic for the one-outstanding issue FSM.
    always_comb begin
        state_d     = state_q;
        pair_d      = pair_q;
        op_valid_d  = op_valid_q;
        res_ready_d = 1'b0;
        wdog_d      = wdog_q;
        issued_d    = issued_q;
        completed_d = completed_q;
        timeout_d   = timeout_q;
        op_pop      = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!op_empty) begin
                    op_pop     = 1'b1;
                    pair_d     = op_head;
                    op_valid_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (op_valid_q && mul.op_ready) begin
                    op_valid_d  = 1'b0;
                    issued_d    = issued_q + CNT_W'(1);
                    wdog_d      = '0;
                    // Raise ready on entry so a fast multiplier is not delayed.
                    res_ready_d = !stall_en && !res_full;
                    state_d     = AWAIT;
                end
            end
            AWAIT: begin
                // Result FIFO cannot fill during AWAIT (only captures push),
                // so the one-cycle lag of the registered ready is safe.
                res_ready_d = !stall_en && !res_full;
                if (mul.res_valid && res_ready_q) begin
                    capture     = 1'b1;
                    completed_d = completed_q + CNT_W'(1);
                    res_ready_d = 1'b0;
                    state_d     = IDLE;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    timeout_d   = 1'b1;
                    res_ready_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pair_q      <= '0;
            op_valid_q  <= 1'b0;
            res_ready_q <= 1'b0;
            wdog_q      <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pair_q      <= pair_d;
            op_valid_q  <= op_valid_d;
            res_ready_q <= res_ready_d;
            wdog_q      <= wdog_d;
            issued_q    <= issued_d;
            completed_q <= completed_d;
            timeout_q   <= timeout_d;
        end
    end

    assign mul.op_a      = pair_q.a;
    assign mul.op_b      = pair_q.b;
    assign mul.op_valid  = op_valid_q;
    assign mul.res_ready = res_ready_q;

    assign rsp_valid     = !res_empty;
    assign rsp_a         = res_head.a;
    assign rsp_b         = res_head.b;
    assign rsp_z         = res_head.z;

    assign issued_cnt    = issued_q;
    assign completed_cnt = completed_q;
    assign timeout_err   = timeout_q;
    assign busy          = (state_q != IDLE) || !op_empty;

endmodule

// File: tb/tb_fpmul_stream_master.sv
// Directed bench for fpmul_stream_master; the bench plays both the host and
// the multiplier wrapper, returning hand-computed IEEE-754 products.
module tb_fpmul_stream_master;
    import fpmul_stream_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [31:0]       cmd_a = '0;
    logic [31:0]       cmd_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_a, rsp_b, rsp_z;
    logic              stall_en = 1'b0;
    logic [CNT_W-1:0]  issued_cnt, completed_cnt;
    logic              timeout_err, busy;

    int checks = 0;
    int errors = 0;

    fpmul_stream_master_if mul();

    always #5 clk = ~clk;

    fpmul_stream_master #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .mul           (mul),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_a         (rsp_a),
        .rsp_b         (rsp_b),
        .rsp_z         (rsp_z),
        .stall_en      (stall_en),
        .issued_cnt    (issued_cnt),
        .completed_cnt (completed_cnt),
        .timeout_err   (timeout_err),
        .busy          (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        checks++;
        if (!cmd_ready) begin errors++; $display("FAIL push_wait: cmd_ready=%b required 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic mul_accept(output logic [31:0] a, output logic [31:0] b);
        int n = 0;
        while (!mul.op_valid && n < 200) begin tick(); n++; end
        checks++;
        if (!mul.op_valid) begin errors++; $display("FAIL accept_wait: op_valid=%b required 1", mul.op_valid); end
        a = mul.op_a; b = mul.op_b;
        mul.op_ready = 1'b1;
        tick();
        mul.op_ready = 1'b0;
    endtask

    task automatic mul_return(input logic [31:0] z);
        int n = 0;
        mul.res_valid = 1'b1; mul.res_data = z;
        while (!mul.res_ready && n < 200) begin tick(); n++; end
        checks++;
        if (!mul.res_ready) begin errors++; $display("FAIL return_wait: res_ready=%b required 1", mul.res_ready); end
        tick();
        mul.res_valid = 1'b0;
    endtask

    task automatic pop(output logic [31:0] a, output logic [31:0] b, output logic [31:0] z);
        int n = 0;
        while (!rsp_valid && n < 200) begin tick(); n++; end
        checks++;
        if (!rsp_valid) begin errors++; $display("FAIL pop_wait: rsp_valid=%b required 1", rsp_valid); end
        a = rsp_a; b = rsp_b; z = rsp_z;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        checks++;
        if ({mul.op_valid, mul.res_ready, rsp_valid, timeout_err, busy} !== 5'b0)
            begin errors++; $display("FAIL reset_flags: got %b required 00000", {mul.op_valid, mul.res_ready, rsp_valid, timeout_err, busy}); end
        checks++;
        if (mul.op_a !== 32'h0 || mul.op_b !== 32'h0)
            begin errors++; $display("FAIL reset_ops: got %h/%h required 0/0", mul.op_a, mul.op_b); end
        checks++;
        if (issued_cnt !== '0 || completed_cnt !== '0 || cmd_ready !== 1'b1)
            begin errors++; $display("FAIL reset_cnt: got %0d/%0d rdy=%b required 0/0 rdy=1", issued_cnt, completed_cnt, cmd_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
    endtask

    // 2.0 * 3.0 = 6.0
    task automatic test_single();
        logic [31:0] a, b, z;
        push(32'h40000000, 32'h40400000);
        mul_accept(a, b);
        checks++;
        if (a !== 32'h40000000 || b !== 32'h40400000)
            begin errors++; $display("FAIL single_ops: got %h/%h required 40000000/40400000", a, b); end
        mul_return(32'h40C00000);
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_latency: rsp_valid=%b required 1", rsp_valid); end
        pop(a, b, z);
        checks++;
        if (a !== 32'h40000000 || b !== 32'h40400000 || z !== 32'h40C00000)
            begin errors++; $display("FAIL single_rsp: got %h %h %h required 40000000 40400000 40c00000", a, b, z); end
        checks++;
        if (issued_cnt !== 16'd1 || completed_cnt !== 16'd1)
            begin errors++; $display("FAIL single_cnt: got %0d/%0d required 1/1", issued_cnt, completed_cnt); end
    endtask

    // 1.0*1.0=1.0, 1.5*-2.0=-3.0, 4.0*0.5=2.0
    task automatic test_back_to_back();
        logic [31:0] va[3], vb[3], vz[3];
        logic [31:0] a, b, z;
        logic [CNT_W-1:0] c0;
        va[0] = 32'h3F800000; vb[0] = 32'h3F800000; vz[0] = 32'h3F800000;
        va[1] = 32'h3FC00000; vb[1] = 32'hC0000000; vz[1] = 32'hC0400000;
        va[2] = 32'h40800000; vb[2] = 32'h3F000000; vz[2] = 32'h40000000;
        c0 = completed_cnt;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_a = va[i]; cmd_b = vb[i];
            checks++;
            if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_cmd_ready[%0d]: got %b required 1", i, cmd_ready); end
            tick();
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mul_accept(a, b);
            checks++;
            if (a !== va[i] || b !== vb[i])
                begin errors++; $display("FAIL b2b_ops[%0d]: got %h/%h required %h/%h", i, a, b, va[i], vb[i]); end
            mul_return(vz[i]);
            checks++;
            if (busy !== (i < 2)) begin errors++; $display("FAIL b2b_busy[%0d]: got %b required %b", i, busy, i < 2); end
        end
        for (int i = 0; i < 3; i++) begin
            pop(a, b, z);
            checks++;
            if (a !== va[i] || b !== vb[i] || z !== vz[i])
                begin errors++; $display("FAIL b2b_order[%0d]: got %h %h %h required %h %h %h", i, a, b, z, va[i], vb[i], vz[i]); end
        end
        checks++;
        if (completed_cnt !== c0 + CNT_W'(3))
            begin errors++; $display("FAIL b2b_cnt: got %0d required %0d", completed_cnt, c0 + CNT_W'(3)); end
    endtask

    // op_ready held low: one pair parks in ISSUE, DEPTH fill the FIFO, the next is held off.
    // Pair i is 2^i * 2.0 = 2^(i+1): exponent field incremented by one.
    task automatic test_fifo_full();
        logic [31:0] a, b, z, ea;
        logic [CNT_W-1:0] i0, c0;
        int acc = 0;
        i0 = issued_cnt; c0 = completed_cnt;
        cmd_valid = 1'b1; cmd_b = 32'h40000000;
        for (int i = 0; i <= DEPTH; i++) begin
            cmd_a = 32'h3F800000 + (i << 23);
            if (cmd_ready) acc++;
            tick();
        end
        checks++;
        if (acc != DEPTH + 1) begin errors++; $display("FAIL full_accepted: got %0d required %0d", acc, DEPTH + 1); end
        cmd_a = 32'h3F800000 + ((DEPTH + 1) << 23);
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_cmd_ready: got %b required 0", cmd_ready); end
        repeat (3) tick();
        checks++;
        if (cmd_ready !== 1'b0 || mul.op_valid !== 1'b1 || mul.op_a !== 32'h3F800000)
            begin errors++; $display("FAIL full_hold: rdy=%b vld=%b a=%h required 0 1 3f800000", cmd_ready, mul.op_valid, mul.op_a); end
        cmd_valid = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            ea = 32'h3F800000 + (i << 23);
            mul_accept(a, b);
            checks++;
            if (a !== ea || b !== 32'h40000000)
                begin errors++; $display("FAIL full_drain_ops[%0d]: got %h/%h required %h/40000000", i, a, b, ea); end
            mul_return(ea + 32'h00800000);
            pop(a, b, z);
            checks++;
            if (a !== ea || z !== ea + 32'h00800000)
                begin errors++; $display("FAIL full_drain_rsp[%0d]: got %h/%h required %h/%h", i, a, z, ea, ea + 32'h00800000); end
        end
        checks++;
        if (busy !== 1'b0 || issued_cnt !== i0 + CNT_W'(DEPTH + 1) || completed_cnt !== c0 + CNT_W'(DEPTH + 1))
            begin errors++; $display("FAIL full_end: busy=%b iss=%0d cmp=%0d required 0 %0d %0d", busy, issued_cnt, completed_cnt, i0 + CNT_W'(DEPTH + 1), c0 + CNT_W'(DEPTH + 1)); end
    endtask

    // 3.0 * 0.5 = 1.5 with result backpressure held for 20 cycles.
    task automatic test_stall();
        logic [31:0] a, b, z;
        logic [CNT_W-1:0] c0;
        int bad = 0;
        int n = 0;
        push(32'h40400000, 32'h3F000000);
        stall_en = 1'b1;
        mul_accept(a, b);
        c0 = completed_cnt;
        mul.res_valid = 1'b1; mul.res_data = 32'h3FC00000;
        repeat (20) begin
            if (mul.res_ready !== 1'b0 || mul.op_a !== 32'h40400000 || mul.op_b !== 32'h3F000000 || completed_cnt !== c0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_hold: %0d bad cycles required 0", bad); end
        stall_en = 1'b0;
        while (!mul.res_ready && n < 10) begin tick(); n++; end
        checks++;
        if (mul.res_ready !== 1'b1) begin errors++; $display("FAIL stall_release: res_ready=%b required 1", mul.res_ready); end
        tick();
        mul.res_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (completed_cnt !== c0 + CNT_W'(1))
            begin errors++; $display("FAIL stall_cnt: got %0d required %0d", completed_cnt, c0 + CNT_W'(1)); end
        pop(a, b, z);
        checks++;
        if (z !== 32'h3FC00000 || rsp_valid !== 1'b0)
            begin errors++; $display("FAIL stall_rsp: z=%h rsp_valid=%b required 3fc00000 0", z, rsp_valid); end
    endtask

    // No response: watchdog fires TIMEOUT cycles after the issue handshake.
    task automatic test_timeout();
        logic [31:0] a, b, z;
        int n = 0;
        push(32'h40000000, 32'h40000000);
        mul_accept(a, b);
        while (!timeout_err && n < 200) begin tick(); n++; end
        checks++;
        if (n != TIMEOUT) begin errors++; $display("FAIL timeout_cycles: got %0d required %0d", n, TIMEOUT); end
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || mul.res_ready !== 1'b0)
            begin errors++; $display("FAIL timeout_state: busy=%b rsp=%b rdy=%b required 0 0 0", busy, rsp_valid, mul.res_ready); end
        // 3.0 * 3.0 = 9.0
        push(32'h40400000, 32'h40400000);
        mul_accept(a, b);
        mul_return(32'h41100000);
        pop(a, b, z);
        checks++;
        if (a !== 32'h40400000 || z !== 32'h41100000 || timeout_err !== 1'b1)
            begin errors++; $display("FAIL timeout_next: a=%h z=%h err=%b required 40400000 41100000 1", a, z, timeout_err); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b;
        push(32'h40000000, 32'h40400000);
        mul_accept(a, b);
        mul_return(32'h40C00000);
        push(32'h3F800000, 32'h3F800000);
        mul_accept(a, b);
        mul_return(32'h3F800000);
        push(32'h40800000, 32'h3F000000);
        mul_accept(a, b);
        checks++;
        if (rsp_valid !== 1'b1 || busy !== 1'b1)
            begin errors++; $display("FAIL mid_pre: rsp=%b busy=%b required 1 1", rsp_valid, busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mul.op_valid, mul.res_ready, rsp_valid, timeout_err, busy, cmd_ready} !== 6'b000001)
            begin errors++; $display("FAIL mid_flags: got %b required 000001", {mul.op_valid, mul.res_ready, rsp_valid, timeout_err, busy, cmd_ready}); end
        checks++;
        if (mul.op_a !== 32'h0 || mul.op_b !== 32'h0 || issued_cnt !== '0 || completed_cnt !== '0)
            begin errors++; $display("FAIL mid_regs: a=%h b=%h iss=%0d cmp=%0d required 0 0 0 0", mul.op_a, mul.op_b, issued_cnt, completed_cnt); end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || mul.op_valid !== 1'b0)
            begin errors++; $display("FAIL mid_after: rsp=%b busy=%b vld=%b required 0 0 0", rsp_valid, busy, mul.op_valid); end
    endtask

    initial begin
        mul.op_ready  = 1'b0;
        mul.res_valid = 1'b0;
        mul.res_data  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_stall();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
